io_controller: RTL

Memory-mapped I/O controller for the single-cycle processor's I/O region. It holds write-back registers for the hex displays and the red and green LEDs, and synchronizes the switches and push-keys. It adds key-press edge capture with sticky write-1-to-clear flags and a maskable interrupt request. All widths and channel counts are parameters. Data memory steers any access whose address decodes to the I/O region into this block.

---
 rtl/io_pkg.sv | 19 +
 rtl/io_if.sv | 13 +
 rtl/io_input_sync.sv | 28 ++
 rtl/io_controller.sv | 122 ++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared constants for the processor I/O region: register word offsets,
// the blank 7-segment pattern and the post-reset key settle time.
package io_pkg;

  localparam logic [2:0] IO_HEX     = 3'd0;
  localparam logic [2:0] IO_LEDR    = 3'd1;
  localparam logic [2:0] IO_LEDG    = 3'd2;
  localparam logic [2:0] IO_SW      = 3'd3;
  localparam logic [2:0] IO_KEY     = 3'd4;
  localparam logic [2:0] IO_KEYEDGE = 3'd5;
  localparam logic [2:0] IO_KEYMASK = 3'd6;

  localparam logic [6:0] HEX_BLANK = 7'h7F;

  // Edges after reset release until the key previous-level register holds a
  // real pin sample rather than the released reset value.
  localparam logic [1:0] KEY_SETTLE = 2'd3;

endpackage

// File: rtl/io_if.sv
// Processor-side bus into the I/O region: word offset, write strobe,
// write data and combinational read data.
interface io_if #(
  parameter int DATA_BIT_WIDTH = 32
);
  logic [2:0]                addr;
  logic                      we;
  logic [DATA_BIT_WIDTH-1:0] dataIn;
  logic [DATA_BIT_WIDTH-1:0] dataOut;

  modport master (output addr, output we, output dataIn, input dataOut);
  modport slave  (input addr, input we, input dataIn, output dataOut);
endinterface

// File: rtl/io_input_sync.sv
// Two-flop synchronizer for asynchronous board inputs with a configurable
// synchronous reset value.
module io_input_sync #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage1;
  logic [WIDTH-1:0] stage2;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      stage1 <= RESET_VALUE;
      stage2 <= RESET_VALUE;
    end else begin
      stage1 <= d;
      stage2 <= stage1;
    end
  end

  assign q = stage2;

endmodule

// File: rtl/io_controller.sv
// Memory-mapped I/O block: hex/LED write-back registers, synchronized switches
// and keys, sticky key-press flags (write-1-to-clear) and a masked interrupt.
module io_controller
  import io_pkg::*;
#(
  parameter int DATA_BIT_WIDTH = 32,
  parameter int NUM_HEX        = 4,
  parameter int NUM_LEDR       = 10,
  parameter int NUM_LEDG       = 8,
  parameter int NUM_SW         = 10,
  parameter int NUM_KEYS       = 4
) (
  input  logic                  clk,
  input  logic                  resetN,
  io_if.slave                   bus,
  input  logic [NUM_SW-1:0]     switches,
  input  logic [NUM_KEYS-1:0]   keys,
  output logic [7*NUM_HEX-1:0]  hex,
  output logic [NUM_LEDR-1:0]   ledr,
  output logic [NUM_LEDG-1:0]   ledg,
  output logic                  irq
);

  logic [7*NUM_HEX-1:0]      hex_q;
  logic [NUM_LEDR-1:0]       ledr_q;
  logic [NUM_LEDG-1:0]       ledg_q;
  logic [NUM_SW-1:0]         sw_sync;
  logic [NUM_KEYS-1:0]       key_sync;
  logic [NUM_KEYS-1:0]       key_prev;
  logic [NUM_KEYS-1:0]       keyedge_q;
  logic [NUM_KEYS-1:0]       keymask_q;
  logic [1:0]                settle_cnt;

  logic                      wr_hex;
  logic                      wr_ledr;
  logic                      wr_ledg;
  logic                      wr_keyedge;
  logic                      wr_keymask;
  logic [NUM_KEYS-1:0]       key_fall;
  logic [NUM_KEYS-1:0]       edge_clr;
  logic [DATA_BIT_WIDTH-1:0] rdata;
  logic                      unused_din;

  io_input_sync #(
    .WIDTH       (NUM_SW),
    .RESET_VALUE ({NUM_SW{1'b0}})
  ) u_sw_sync (
    .clk    (clk),
    .resetN (resetN),
    .d      (switches),
    .q      (sw_sync)
  );

  io_input_sync #(
    .WIDTH       (NUM_KEYS),
    .RESET_VALUE ({NUM_KEYS{1'b1}})
  ) u_key_sync (
    .clk    (clk),
    .resetN (resetN),
    .d      (keys),
    .q      (key_sync)
  );

  // Bit 7 of each HEX byte and bits above each field are deliberately ignored.
  assign unused_din = ^bus.dataIn;

  always_comb begin
    wr_hex     = bus.we && (bus.addr == IO_HEX);
    wr_ledr    = bus.we && (bus.addr == IO_LEDR);
    wr_ledg    = bus.we && (bus.addr == IO_LEDG);
    wr_keyedge = bus.we && (bus.addr == IO_KEYEDGE);
    wr_keymask = bus.we && (bus.addr == IO_KEYMASK);
    edge_clr   = wr_keyedge ? bus.dataIn[NUM_KEYS-1:0] : '0;
    // A key held through reset only counts once it has been seen released.
    key_fall   = key_prev & ~key_sync & {NUM_KEYS{settle_cnt == 2'd0}};
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      hex_q      <= {NUM_HEX{HEX_BLANK}};
      ledr_q     <= '0;
      ledg_q     <= '0;
      key_prev   <= '1;
      keyedge_q  <= '0;
      keymask_q  <= '0;
      settle_cnt <= KEY_SETTLE;
    end else begin
      if (settle_cnt != 2'd0) settle_cnt <= settle_cnt - 2'd1;
      key_prev  <= key_sync;
      keyedge_q <= (keyedge_q & ~edge_clr) | key_fall;
      if (wr_hex) begin
        for (int i = 0; i < NUM_HEX; i++) hex_q[7*i +: 7] <= bus.dataIn[8*i +: 7];
      end
      if (wr_ledr)    ledr_q    <= bus.dataIn[NUM_LEDR-1:0];
      if (wr_ledg)    ledg_q    <= bus.dataIn[NUM_LEDG-1:0];
      if (wr_keymask) keymask_q <= bus.dataIn[NUM_KEYS-1:0];
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.addr)
      IO_HEX: begin
        for (int i = 0; i < NUM_HEX; i++) rdata[8*i +: 7] = hex_q[7*i +: 7];
      end
      IO_LEDR:    rdata[NUM_LEDR-1:0] = ledr_q;
      IO_LEDG:    rdata[NUM_LEDG-1:0] = ledg_q;
      IO_SW:      rdata[NUM_SW-1:0]   = sw_sync;
      IO_KEY:     rdata[NUM_KEYS-1:0] = key_sync;
      IO_KEYEDGE: rdata[NUM_KEYS-1:0] = keyedge_q;
      IO_KEYMASK: rdata[NUM_KEYS-1:0] = keymask_q;
      default:    rdata = '0;
    endcase
  end

  assign bus.dataOut = rdata;
  assign hex         = hex_q;
  assign ledr        = ledr_q;
  assign ledg        = ledg_q;
  assign irq         = |(keyedge_q & keymask_q);

endmodule
